vtimer_multi: RTL and testbench
===============================

// Module: vtimer_multi
// PURPOSE
//  Multi-channel programmable interval timer; parametrised successor of the fixed 4-cycle timer.
//  A shared prescaler generates a tick. NUM_CH independent channel counters count ticks up to a
//  per-channel runtime terminal value, in periodic or one-shot mode.
//  Sits beside the control FSMs; drives their timeouts and periodic events.
// PARAMETERS
//  WIDTH   32  channel counter and terminal width, in bits
//  PRE_W   16  prescaler counter and prescale width, in bits
//  NUM_CH  4   number of channels (>=1)
// PORTS
//  clk          in   1             clock; all logic rises on posedge
//  sync_reset   in   1             synchronous, active-high reset
//  enable       in   1             global run; low freezes prescaler and all channels
//  prescale     in   PRE_W         tick every prescale+1 enabled cycles
//  ch_en        in   NUM_CH        per-channel count enable
//  ch_oneshot   in   NUM_CH        1 = one-shot, 0 = periodic
//  ch_clear     in   NUM_CH        per-channel synchronous clear
//  ch_terminal  in   NUM_CH*WIDTH  terminal value; channel i is bits [i*WIDTH +: WIDTH]
//  ch_count     out  NUM_CH*WIDTH  current count per channel
//  ch_elapsed   out  NUM_CH        one-cycle pulse per terminal event
//  ch_done      out  NUM_CH        one-shot channel has expired and stopped
//  irq          out  NUM_CH        interrupt; see CONFIGURATION
//  irq_ack      in   NUM_CH        interrupt acknowledge
// BEHAVIOUR
//  - Reset: prescaler, all counts, ch_elapsed, ch_done and irq are 0. Reset overrides every input.
//  - Prescaler: while enable=1, pre_cnt counts 0..prescale, then wraps to 0.
//    tick=1 (combinational) in a cycle where enable=1 and pre_cnt>=prescale.
//    prescale=0 gives a tick every enabled cycle. Lowering prescale below pre_cnt wraps on the next enabled cycle.
//  - Channel i counts when tick & ch_en[i] & !ch_done[i]:
//      cnt<terminal  -> cnt+1
//      cnt>=terminal -> terminal event: ch_elapsed[i] is set high for the next cycle only.
//                       periodic: cnt<=0.  one-shot: cnt holds, ch_done[i]<=1.
//    terminal=0 gives an event on every tick. cnt>terminal (terminal lowered live) counts as an event.
//  - Period: (terminal+1)*(prescale+1) enabled cycles. Each elapsed pulse is registered, 1 cycle after the event tick.
//  - ch_clear[i] beats a same-cycle tick: cnt<=0, ch_done<=0, no elapsed pulse.
//    ch_clear does not touch the prescaler. Only reset clears the prescaler.
//  - enable=0 or ch_en=0: counts hold and no events occur. ch_elapsed still drops after 1 cycle.
//  - A done one-shot channel ignores ticks until ch_clear or reset. Re-arming = clear, then keep ch_en high.
//  - Counter arithmetic is unsigned, WIDTH bits. No wrap past 2^WIDTH-1 is possible, because the terminal caps it.
// CONFIGURATION
//  VTIMER_IRQ_STICKY_EN defined:
//    irq[i] is set by a terminal event. It is cleared on the cycle after irq_ack[i]=1.
//    Set beats ack in the same cycle.
//  Not defined: irq = ch_elapsed and irq_ack is ignored. No sticky flops are built.
// STRUCTURE
//  vtimer_pkg holds:
//    - counter control codes CTRL_NONE/LOAD/INCR/DECR (2-bit);
//    - MODE_PERIODIC/MODE_ONESHOT constants.
//  vtimer_channel: one counter, its elapsed/done flops and the optional sticky irq flop.
//    Instantiated NUM_CH times in a generate loop. The prescaler stays in vtimer_multi.
// TESTING
//  1. WIDTH=32, prescale=0, ch0 periodic, terminal=3, enable=ch_en=1
//     -> ch_elapsed[0] pulses every 4 cycles; count runs 0,1,2,3,0.
//  2. prescale=2, terminal=1 -> elapsed every 6 cycles; prescale=0, terminal=0 -> elapsed every cycle.
//  3. One-shot, terminal=5 -> single pulse, ch_done=1, count holds at 5.
//     Then ch_clear -> count=0, done=0, and timing restarts.
//  4. ch_clear asserted on the event tick -> no pulse, count=0. enable low for 10 cycles mid-count -> count and phase frozen.
//  5. terminal lowered from 100 to 10 while count=50 -> event on the next tick, count=0.
//     sync_reset mid-count -> all outputs 0 on the next cycle.
//  6. With VTIMER_IRQ_STICKY_EN: irq stays high until irq_ack; ack in the same cycle as an event keeps irq=1.
//     Without the macro: irq mirrors ch_elapsed.

Source files
------------

// File: rtl/vtimer_pkg.sv
// Shared definitions for the multi-channel interval timer: counter control codes
// and channel mode encodings.
package vtimer_pkg;

    typedef enum logic [1:0] {
        CTRL_NONE = 2'd0,
        CTRL_LOAD = 2'd1,
        CTRL_INCR = 2'd2,
        CTRL_DECR = 2'd3
    } ctrl_e;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/vtimer_channel.sv
// One timer channel: tick counter with terminal compare, elapsed/done flops and,
// when VTIMER_IRQ_STICKY_EN is defined, a sticky interrupt flop.
module vtimer_channel
    import vtimer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             sync_reset,
    input  logic             i_tick,
    input  logic             i_en,
    input  logic             i_oneshot,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_terminal,
    input  logic             i_irq_ack,
    output logic [WIDTH-1:0] o_count,
    output logic             o_elapsed,
    output logic             o_done,
    output logic             o_irq
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_cnt;
    logic             r_elapsed;
    logic             r_done;
    logic             w_active;
    logic             w_at_term;
    logic             w_event;
    ctrl_e            w_ctrl;

    assign w_active  = i_tick & i_en & ~r_done;
    // >= rather than == so a terminal lowered below the live count still fires
    assign w_at_term = (r_cnt >= i_terminal);
    assign w_event   = w_active & w_at_term & ~i_clear;

    always_comb begin
        w_ctrl = CTRL_NONE;
        if (i_clear) begin
            w_ctrl = CTRL_LOAD;
        end else if (w_active) begin
            if (!w_at_term) begin
                w_ctrl = CTRL_INCR;
            end else if (i_oneshot == MODE_PERIODIC) begin
                w_ctrl = CTRL_LOAD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            r_cnt     <= '0;
            r_elapsed <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (w_ctrl)
                CTRL_LOAD: r_cnt <= '0;
                CTRL_INCR: r_cnt <= r_cnt + ONE;
                CTRL_DECR: r_cnt <= r_cnt - ONE;
                default:   r_cnt <= r_cnt;
            endcase
            r_elapsed <= w_event;
            if (i_clear) begin
                r_done <= 1'b0;
            end else if (w_event && (i_oneshot == MODE_ONESHOT)) begin
                r_done <= 1'b1;
            end
        end
    end

`ifdef VTIMER_IRQ_STICKY_EN
    logic r_irq;

    // a new event wins over an acknowledge arriving in the same cycle
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            r_irq <= 1'b0;
        end else if (w_event) begin
            r_irq <= 1'b1;
        end else if (i_irq_ack) begin
            r_irq <= 1'b0;
        end
    end

    assign o_irq = r_irq;
`else
    logic w_unused_ack;

    assign w_unused_ack = i_irq_ack;
    assign o_irq        = r_elapsed;
`endif

    assign o_count   = r_cnt;
    assign o_elapsed = r_elapsed;
    assign o_done    = r_done;

endmodule

// File: rtl/vtimer_multi.sv
// Multi-channel programmable interval timer: shared prescaler tick feeding NUM_CH
// channel counters. VTIMER_IRQ_STICKY_EN selects sticky interrupts per channel.
module vtimer_multi
    import vtimer_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int PRE_W  = 16,
    parameter int NUM_CH = 4
) (
    input  logic                    clk,
    input  logic                    sync_reset,
    input  logic                    enable,
    input  logic [PRE_W-1:0]        prescale,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic [NUM_CH-1:0]       ch_oneshot,
    input  logic [NUM_CH-1:0]       ch_clear,
    input  logic [NUM_CH*WIDTH-1:0] ch_terminal,
    output logic [NUM_CH*WIDTH-1:0] ch_count,
    output logic [NUM_CH-1:0]       ch_elapsed,
    output logic [NUM_CH-1:0]       ch_done,
    output logic [NUM_CH-1:0]       irq,
    input  logic [NUM_CH-1:0]       irq_ack
);

    localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);

    logic [PRE_W-1:0] r_pre_cnt;
    logic             w_tick;

    // >= lets a prescale lowered below the live count wrap on the next cycle
    assign w_tick = enable & (r_pre_cnt >= prescale);

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            r_pre_cnt <= '0;
        end else if (enable) begin
            if (w_tick) begin
                r_pre_cnt <= '0;
            end else begin
                r_pre_cnt <= r_pre_cnt + PRE_ONE;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        vtimer_channel #(
            .WIDTH (WIDTH)
        ) u_ch (
            .clk        (clk),
            .sync_reset (sync_reset),
            .i_tick     (w_tick),
            .i_en       (ch_en[g]),
            .i_oneshot  (ch_oneshot[g]),
            .i_clear    (ch_clear[g]),
            .i_terminal (ch_terminal[g*WIDTH +: WIDTH]),
            .i_irq_ack  (irq_ack[g]),
            .o_count    (ch_count[g*WIDTH +: WIDTH]),
            .o_elapsed  (ch_elapsed[g]),
            .o_done     (ch_done[g]),
            .o_irq      (irq[g])
        );
    end

endmodule

// File: tb/tb_vtimer_multi.sv
// Directed self-checking bench for vtimer_multi (WIDTH=32, PRE_W=16, NUM_CH=4).
// Irq expectations follow VTIMER_IRQ_STICKY_EN when it is defined.
module tb_vtimer_multi;

    logic         clk;
    logic         sync_reset;
    logic         enable;
    logic [15:0]  prescale;
    logic [3:0]   ch_en;
    logic [3:0]   ch_oneshot;
    logic [3:0]   ch_clear;
    logic [127:0] ch_terminal;
    logic [127:0] ch_count;
    logic [3:0]   ch_elapsed;
    logic [3:0]   ch_done;
    logic [3:0]   irq;
    logic [3:0]   irq_ack;

    int n_checks;
    int n_errors;

    vtimer_multi #(
        .WIDTH  (32),
        .PRE_W  (16),
        .NUM_CH (4)
    ) dut (
        .clk         (clk),
        .sync_reset  (sync_reset),
        .enable      (enable),
        .prescale    (prescale),
        .ch_en       (ch_en),
        .ch_oneshot  (ch_oneshot),
        .ch_clear    (ch_clear),
        .ch_terminal (ch_terminal),
        .ch_count    (ch_count),
        .ch_elapsed  (ch_elapsed),
        .ch_done     (ch_done),
        .irq         (irq),
        .irq_ack     (irq_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        sync_reset = 1'b1;
        step();
        step();
        sync_reset = 1'b0;
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        sync_reset  = 1'b1;
        enable      = 1'b1;
        prescale    = 16'd0;
        ch_en       = 4'b1111;
        ch_oneshot  = 4'b0000;
        ch_clear    = 4'b0000;
        irq_ack     = 4'b0000;
        ch_terminal = '0;

        // reset overrides active inputs
        step();
        step();
        chk("rst_count", ch_count, 128'd0);
        chk("rst_elapsed", ch_elapsed, 4'd0);
        chk("rst_done", ch_done, 4'd0);
        chk("rst_irq", irq, 4'd0);

        // periodic, prescale 0: ch0 term 3, ch1 term 2, ch2 disabled
        ch_en       = 4'b0011;
        ch_terminal = {32'd0, 32'd7, 32'd2, 32'd3};
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("t1_cnt0", ch_count[31:0], k % 4);
            chk("t1_elap0", ch_elapsed[0], (k % 4) == 0);
`ifndef VTIMER_IRQ_STICKY_EN
            chk("t1_irq0", irq[0], (k % 4) == 0);
`endif
            chk("t1_cnt1", ch_count[63:32], k % 3);
        end
        chk("t1_cnt2_off", ch_count[95:64], 32'd0);

        // prescale 2, terminal 1: event every 6 cycles
        ch_en       = 4'b0001;
        prescale    = 16'd2;
        ch_terminal = {96'd0, 32'd1};
        do_reset();
        for (int k = 1; k <= 13; k++) begin
            step();
            chk("t2_cnt", ch_count[31:0], (k / 3) % 2);
            chk("t2_elap", ch_elapsed[0], (k % 6) == 0);
        end

        // prescale 0, terminal 0: event every cycle
        prescale    = 16'd0;
        ch_terminal = '0;
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("t2b_elap", ch_elapsed[0], 1'b1);
            chk("t2b_cnt", ch_count[31:0], 32'd0);
        end

        // one-shot terminal 5, then clear and re-run
        ch_oneshot  = 4'b0001;
        ch_terminal = {96'd0, 32'd5};
        do_reset();
        for (int k = 1; k <= 9; k++) begin
            step();
            chk("t3_cnt", ch_count[31:0], (k < 5) ? k : 5);
            chk("t3_elap", ch_elapsed[0], k == 6);
            chk("t3_done", ch_done[0], k >= 6);
        end
        ch_clear = 4'b0001;
        step();
        chk("t3_clr_cnt", ch_count[31:0], 32'd0);
        chk("t3_clr_done", ch_done[0], 1'b0);
        chk("t3_clr_elap", ch_elapsed[0], 1'b0);
        ch_clear = 4'b0000;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk("t3r_cnt", ch_count[31:0], (k < 5) ? k : 5);
            chk("t3r_elap", ch_elapsed[0], k == 6);
            chk("t3r_done", ch_done[0], k >= 6);
        end

        // clear on the event tick suppresses the pulse
        ch_oneshot  = 4'b0000;
        ch_terminal = {96'd0, 32'd3};
        do_reset();
        step();
        step();
        step();
        chk("t4_pre_cnt", ch_count[31:0], 32'd3);
        ch_clear = 4'b0001;
        step();
        chk("t4_clr_cnt", ch_count[31:0], 32'd0);
        chk("t4_clr_elap", ch_elapsed[0], 1'b0);
        ch_clear = 4'b0000;
        step();
        chk("t4_after_cnt", ch_count[31:0], 32'd1);

        // enable low freezes count and prescaler phase
        prescale = 16'd1;
        do_reset();
        repeat (5) step();
        chk("t4f_cnt", ch_count[31:0], 32'd2);
        enable = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("t4f_hold", ch_count[31:0], 32'd2);
            chk("t4f_elap", ch_elapsed[0], 1'b0);
        end
        enable = 1'b1;
        step();
        chk("t4f_res1", ch_count[31:0], 32'd3);
        step();
        chk("t4f_res2", ch_count[31:0], 32'd3);
        chk("t4f_res2_elap", ch_elapsed[0], 1'b0);
        step();
        chk("t4f_res3", ch_count[31:0], 32'd0);
        chk("t4f_res3_elap", ch_elapsed[0], 1'b1);

        // terminal lowered below count; ch1 one-shot term 0 expires at once
        prescale    = 16'd0;
        ch_en       = 4'b0011;
        ch_oneshot  = 4'b0010;
        ch_terminal = {64'd0, 32'd0, 32'd100};
        do_reset();
        repeat (50) step();
        chk("t5_cnt50", ch_count[31:0], 32'd50);
        chk("t5_done1", ch_done[1], 1'b1);
        ch_terminal = {64'd0, 32'd0, 32'd10};
        step();
        chk("t5_low_cnt", ch_count[31:0], 32'd0);
        chk("t5_low_elap", ch_elapsed[0], 1'b1);
        repeat (3) step();
        chk("t5_cnt3", ch_count[31:0], 32'd3);
        sync_reset = 1'b1;
        step();
        chk("t5_rst_count", ch_count, 128'd0);
        chk("t5_rst_elap", ch_elapsed, 4'd0);
        chk("t5_rst_done", ch_done, 4'd0);
        chk("t5_rst_irq", irq, 4'd0);
        sync_reset = 1'b0;

        // irq behaviour with acknowledge
        ch_en       = 4'b0001;
        ch_oneshot  = 4'b0000;
        ch_terminal = {96'd0, 32'd1};
        do_reset();
        step();
        chk("t6_irq_e1", irq[0], 1'b0);
        step();
        chk("t6_irq_e2", irq[0], 1'b1);
        step();
`ifdef VTIMER_IRQ_STICKY_EN
        chk("t6_irq_e3", irq[0], 1'b1);
`else
        chk("t6_irq_e3", irq[0], 1'b0);
`endif
        irq_ack = 4'b0001;
        step();
        chk("t6_irq_e4", irq[0], 1'b1);
        step();
        chk("t6_irq_e5", irq[0], 1'b0);
        irq_ack = 4'b0000;
        step();
        chk("t6_irq_e6", irq[0], 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
